// File: rtl/noc_arb_pkg.sv
// Shared definitions for the router output-port arbiters.
// Port indices, arbiter state encoding and default buffer depth.
package noc_arb_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  localparam int NUM_PORTS_DEF = 5;
  localparam int BUF_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set req bit after rr_ptr, wrapping.
// Purely combinational; shared by all output-port arbiters.
module rr_priority_picker #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 found
);

  logic [IDX_W-1:0] w_idx;

  // Scan rr_ptr+1 .. rr_ptr+NUM_PORTS, keep the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_idx  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!found && req[w_idx]) begin
        winner = w_idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_credit_arbiter.sv
// Output-channel scheduler: packet-level round-robin with
// wormhole locking and credit-based flow control.
module wormhole_credit_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 credit_in,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     credit_cnt,
  output logic                 err_overflow
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;
  logic [CNT_W-1:0] r_credit;
  logic             r_err;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_found;
  logic [NUM_PORTS-1:0] w_owner_oh;
  logic                 w_send;

  rr_priority_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req   (req),
    .rr_ptr(r_rr_ptr),
    .winner(w_winner),
    .found (w_found)
  );

  assign w_owner_oh = NUM_PORTS'(1) << r_owner;
  // No credit bypass: grant uses only the registered count.
  assign w_send = (r_state == LOCKED) && req[r_owner]
                  && (r_credit != '0);

  // Crossbar select and grant for the locked owner.
  always_comb begin
    grant    = '0;
    xbar_sel = '0;
    if (r_state == LOCKED) begin
      xbar_sel = w_owner_oh;
      if (w_send) grant = w_owner_oh;
    end
  end

  assign valid_out    = |grant;
  assign credit_cnt   = r_credit;
  assign err_overflow = r_err;

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= IDX_W'(PORT_S);
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Lock a winner in IDLE; release after the tail flit is sent.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_winner;
        end
      end
      LOCKED: begin
        if (w_send && tail[r_owner]) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Credit counter with saturation and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= FULL;
      r_err    <= 1'b0;
    end else if (credit_in && !valid_out) begin
      if (r_credit == FULL) r_err <= 1'b1;
      else r_credit <= r_credit + 1'b1;
    end else if (!credit_in && valid_out) begin
      r_credit <= r_credit - 1'b1;
    end
  end

endmodule

// File: tb/tb_wormhole_credit_arbiter.sv
// Directed testbench for wormhole_credit_arbiter.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_wormhole_credit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] grant;
  logic [4:0] xbar_sel;
  logic       valid_out;
  logic [2:0] credit_cnt;
  logic       err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  wormhole_credit_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .tail        (tail),
    .credit_in   (credit_in),
    .grant       (grant),
    .xbar_sel    (xbar_sel),
    .valid_out   (valid_out),
    .credit_cnt  (credit_cnt),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tail = '0;
    credit_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tail = '0;
    credit_in = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0 || xbar_sel !== 5'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: grant=%b xbar=%b valid=%b want 0",
               grant, xbar_sel, valid_out);
    end
    n_tests++;
    if (credit_cnt !== 3'd4 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_credit: cnt=%0d err=%b want 4/0",
               credit_cnt, err_overflow);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_first_packet();
    logic [2:0] exp_cnt [3] = '{3'd4, 3'd3, 3'd2};
    do_reset();
    req = 5'b10001;
    tail = 5'b00000;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0) begin
      n_fail++;
      $display("FAIL t1_idle: grant=%b want 00000", grant);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      tail = (i == 2) ? 5'b10000 : 5'b00000;
      @(negedge clk);
      n_tests++;
      if (grant !== 5'b10000 || credit_cnt !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL t1_L_flit%0d: grant=%b cnt=%0d want 10000/%0d",
                 i, grant, credit_cnt, exp_cnt[i]);
      end
      tick();
    end
    req = 5'b00001;
    tail = 5'b00000;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0 || xbar_sel !== 5'b0 || credit_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL t1_bubble: grant=%b xbar=%b cnt=%0d want 0/0/1",
               grant, xbar_sel, credit_cnt);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b00001 || xbar_sel !== 5'b00001) begin
      n_fail++;
      $display("FAIL t1_N_lock: grant=%b xbar=%b want 00001/00001",
               grant, xbar_sel);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] order [6] = '{5'b10000, 5'b00001, 5'b00010,
                              5'b00100, 5'b01000, 5'b10000};
    do_reset();
    req = 5'b11111;
    tail = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      credit_in = 1'b0;
      @(negedge clk);
      n_tests++;
      if (grant !== 5'b0) begin
        n_fail++;
        $display("FAIL rr_bubble%0d: grant=%b want 00000", k, grant);
      end
      tick();
      credit_in = 1'b1;
      @(negedge clk);
      n_tests++;
      if (grant !== order[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b want %b",
                 k, grant, order[k]);
      end
      tick();
    end
    credit_in = 1'b0;
    req = '0;
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL rr_credit: cnt=%0d want 4", credit_cnt);
    end
    tick();
  endtask

  task automatic test_credit_stall();
    do_reset();
    req = 5'b00010;
    tail = 5'b00000;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant !== 5'b00010) begin
        n_fail++;
        $display("FAIL stall_grant%0d: grant=%b want 00010", i, grant);
      end
      tick();
    end
    credit_in = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0 || credit_cnt !== 3'd0 || xbar_sel !== 5'b00010) begin
      n_fail++;
      $display("FAIL stall_empty: grant=%b cnt=%0d xbar=%b want 0/0/00010",
               grant, credit_cnt, xbar_sel);
    end
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b00010 || credit_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL stall_resume: grant=%b cnt=%0d want 00010/1",
               grant, credit_cnt);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0 || credit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_again: grant=%b cnt=%0d want 0/0",
               grant, credit_cnt);
    end
    tick();
  endtask

  task automatic test_wormhole_hold();
    do_reset();
    req = 5'b00100;
    tail = 5'b00000;
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b00100) begin
      n_fail++;
      $display("FAIL hold_first: grant=%b want 00100", grant);
    end
    tick();
    req = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant !== 5'b0 || xbar_sel !== 5'b00100) begin
        n_fail++;
        $display("FAIL hold_gap%0d: grant=%b xbar=%b want 0/00100",
                 i, grant, xbar_sel);
      end
      tick();
    end
    req = 5'b00101;
    tail = 5'b00100;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b00100 || credit_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL hold_tail: grant=%b cnt=%0d want 00100/3",
               grant, credit_cnt);
    end
    tick();
    req = 5'b00001;
    tail = 5'b00000;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b0 || xbar_sel !== 5'b0) begin
      n_fail++;
      $display("FAIL hold_bubble: grant=%b xbar=%b want 0/0",
               grant, xbar_sel);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b00001) begin
      n_fail++;
      $display("FAIL hold_next_N: grant=%b want 00001", grant);
    end
    tick();
  endtask

  task automatic test_credit_overflow();
    do_reset();
    req = 5'b01000;
    tail = 5'b00000;
    tick();
    tick();
    tick();
    credit_in = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b01000 || credit_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL ovf_sim_pre: grant=%b cnt=%0d want 01000/2",
               grant, credit_cnt);
    end
    tick();
    req = 5'b00000;
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd2 || grant !== 5'b0) begin
      n_fail++;
      $display("FAIL ovf_sim_post: cnt=%0d grant=%b want 2/0",
               credit_cnt, grant);
    end
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd4 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: cnt=%0d err=%b want 4/0",
               credit_cnt, err_overflow);
    end
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd4 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: cnt=%0d err=%b want 4/1",
               credit_cnt, err_overflow);
    end
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: err=%b want 1", err_overflow);
    end
    tick();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: err=%b want 0", err_overflow);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req = 5'b10000;
    tail = 5'b00000;
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd1 || grant !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_pre: cnt=%0d grant=%b want 1/10000",
               credit_cnt, grant);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 5'b10001;
    @(negedge clk);
    n_tests++;
    if (credit_cnt !== 3'd4 || grant !== 5'b0 || xbar_sel !== 5'b0) begin
      n_fail++;
      $display("FAIL rstmid_post: cnt=%0d grant=%b xbar=%b want 4/0/0",
               credit_cnt, grant, xbar_sel);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_pickL: grant=%b want 10000", grant);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_first_packet();
    test_round_robin();
    test_credit_stall();
    test_wormhole_hold();
    test_credit_overflow();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wormhole_credit_arbiter.md
Name: wormhole_credit_arbiter

Overview:
Output-port scheduler for one router output channel, shared between the five input ports N, E, W and S and the local port L. It arbitrates at packet granularity with round-robin priority. It holds the crossbar for the winner from header through tail flit (wormhole locking). It gates every flit transfer on credit-based flow control against the downstream input buffer.

Parameters:
NUM_PORTS, 5, number of requesters; bit index 0=N, 1=E, 2=W, 3=S, 4=L
BUF_DEPTH, 4, downstream buffer depth in flits; this is the initial credit count
CNT_W, $clog2(BUF_DEPTH+1), credit counter width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req  input  NUM_PORTS  per-port flit-available; port i has a flit at its head
tail  input  NUM_PORTS  per-port; the head flit of port i is a tail flit (ignored when req[i]=0)
credit_in  input  1  one-cycle pulse; downstream freed one buffer slot
grant  output  NUM_PORTS  one-hot or zero; the flit of port i is transferred this cycle
xbar_sel  output  NUM_PORTS  one-hot crossbar select of the locked owner; zero when idle
valid_out  output  1  flit driven downstream this cycle; equals |grant
credit_cnt  output  CNT_W  current available credits
err_overflow  output  1  sticky; set when credit_in arrives while credit_cnt==BUF_DEPTH and no flit is sent

Behaviour:
- Reset values:
  - state=IDLE, owner=0, rr_ptr=3, so port L has first priority.
  - credit_cnt=BUF_DEPTH, err_overflow=0.
  - grant, xbar_sel and valid_out are 0.
- States:
  - IDLE: no grant, xbar_sel=0.
    - If req!=0, the picker chooses the first set req bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
    - The winner is registered into owner and the state moves to LOCKED on the next edge.
    - With rr_ptr=3 the scan order is L, N, E, W, S.
  - LOCKED:
    - xbar_sel = onehot(owner).
    - grant[owner] = req[owner] & (credit_cnt!=0), combinational from registered credit_cnt.
    - There is no credit bypass: credit_in arriving in the same cycle with credit_cnt==0 does not enable a grant.
    - When a grant occurs with tail[owner]=1, the state returns to IDLE and rr_ptr<=owner on the next edge.
    - A single-flit packet (header with tail) behaves the same way.
- Latency:
  - A request in IDLE at cycle t gives the earliest grant in cycle t+1.
  - After a tail grant there is one IDLE bubble cycle before the next packet is granted.
- Owner req deasserted mid-packet: the state stays LOCKED with no grant. Other requesters are ignored until the tail, so there is no preemption.
- Requests from non-owners never affect grant while LOCKED.
- Credit counter:
  - next = credit_cnt + credit_in - valid_out.
  - A simultaneous credit_in and send leaves it unchanged.
  - It never underflows, because a grant requires credit_cnt>0.
  - On overflow the counter saturates at BUF_DEPTH and err_overflow is set, held until rst.
- Reset mid-packet: the lock is abandoned, credits are restored to BUF_DEPTH and rr_ptr returns to 3. Upstream and downstream are reset together.
- grant is never asserted in IDLE or for any port other than owner.

Decomposition:
- Package noc_arb_pkg holds:
  - port index constants PORT_N=0, PORT_E=1, PORT_W=2, PORT_S=3, PORT_L=4;
  - enum arb_state_t {IDLE, LOCKED};
  - default BUF_DEPTH.
- One combinational sub-module, rr_priority_picker.
  - Inputs: req and rr_ptr. Outputs: winner index and found flag.
  - It is reused by the other output-port arbiters.
- The FSM, credit counter and grant logic stay in wormhole_credit_arbiter.

Test Plan:
1. After reset, assert req=5'b10001 (N and L), 3-flit packets, credit_in held 0. Expected:
   - L is locked first, grant[4] in cycles 1-3 and credit_cnt goes 4 to 1;
   - one IDLE cycle follows, then N is locked.
2. Round-robin fairness: all req=1 with single-flit packets (tail=1). Expected grant order L, N, E, W, S, L with one bubble between grants. Return credit_in each send.
3. Credit stall: lock E with a 6-flit packet, BUF_DEPTH=4, no credit_in. Expected:
   - 4 grants, then credit_cnt=0 and grant=0 while xbar_sel stays 5'b00010;
   - one credit_in pulse gives exactly one further grant, 1 cycle later.
4. Wormhole hold: lock W, then drop req[2] for 3 cycles while req[0]=1. Expected grant=0 and xbar_sel stays 5'b00100; W resumes when req[2] returns, with no switch to N before tail.
5. Simultaneous credit_in with a send at credit_cnt=2: credit_cnt stays 2. Then credit_in at credit_cnt=4 with no send: credit_cnt stays 4 and err_overflow=1, held until rst.
6. rst asserted mid-packet at credit_cnt=1: next cycle state=IDLE, credit_cnt=4, grant=0, and the first arbitration picks L.
